// File: rtl/ul8_pkg.sv
// Shared definitions for the UL8 sequencer: opcode classes, ALU op codes, FSM states.
// Pure declarations, no logic; imported by the decoder, the sequencer and the bench.
// No flow control of its own.
package ul8_pkg;

    localparam logic [3:0] CLS_ALU   = 4'h0;
    localparam logic [3:0] CLS_LOAD  = 4'h1;
    localparam logic [3:0] CLS_STORE = 4'h2;
    localparam logic [3:0] CLS_JMP   = 4'h3;
    localparam logic [3:0] CLS_JZ    = 4'h4;
    localparam logic [3:0] CLS_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_NAND = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_ZERO = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH_OP  = 3'd0,
        ST_FETCH_ARG = 3'd1,
        ST_EXEC_RD   = 3'd2,
        ST_EXEC_WR   = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_jmp;
        logic is_jz;
        logic is_halt;
        logic two_byte;
    } dec_t;

endpackage

// File: rtl/ul8_decode.sv
// Opcode-class decoder for UL8; UL8_ZERO_FLAG_EN selects JZ as a branch or as a two-byte NOP.
// Purely combinational, zero latency.
// No flow control; the caller decides when the decoded class is acted on.
module ul8_decode
    import ul8_pkg::*;
(
    input  logic [3:0] op_class,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (op_class)
            CLS_ALU: begin
                dec.is_alu   = 1'b1;
                dec.two_byte = 1'b1;
            end
            CLS_LOAD: begin
                dec.is_load  = 1'b1;
                dec.two_byte = 1'b1;
            end
            CLS_STORE: begin
                dec.is_store = 1'b1;
                dec.two_byte = 1'b1;
            end
            CLS_JMP: begin
                dec.is_jmp   = 1'b1;
                dec.two_byte = 1'b1;
            end
            CLS_JZ: begin
`ifdef UL8_ZERO_FLAG_EN
                dec.is_jz    = 1'b1;
`endif
                // Without the flag the argument is still consumed, so PC advances by 2.
                dec.two_byte = 1'b1;
            end
            CLS_HALT: begin
                dec.is_halt  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ul8_sequencer.sv
// UL8 fetch/execute controller driving the ALU and a shared 8-bit memory; UL8_ZERO_FLAG_EN enables the zero flag and JZ.
// Zero-wait latency: NOP/HALT 1 cycle, JMP/JZ 2, ALU/LOAD/STORE 3.
// Each request is held with a stable address until mem_ack_in; every low-ack cycle adds one cycle.
module ul8_sequencer
    import ul8_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    output logic [7:0] mem_addr_out,
    output logic       mem_rd_out,
    output logic       mem_wr_out,
    output logic [7:0] mem_wdata_out,
    input  logic [7:0] mem_rdata_in,
    input  logic       mem_ack_in,
    output logic [7:0] alu_x_out,
    output logic [7:0] alu_y_out,
    output logic [1:0] alu_op_out,
    input  logic [7:0] alu_z_in,
    output logic [7:0] acc_out,
    output logic [7:0] pc_out,
    output logic       zero_out,
    output logic       halted_out
);

    state_t     state;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [7:0] ir;
    logic [7:0] ar;
    logic [7:0] dec_src;
    logic [7:0] acc_nxt;
    logic       zero_flag;
    logic       take_jump;
    dec_t       dec;

    // In FETCH_OP the opcode is still on the bus; afterwards it lives in IR.
    assign dec_src = (state == ST_FETCH_OP) ? mem_rdata_in : ir;

    ul8_decode u_decode (
        .op_class (dec_src[7:4]),
        .dec      (dec)
    );

    assign acc_nxt   = dec.is_alu ? alu_z_in : mem_rdata_in;
    assign take_jump = dec.is_jmp || (dec.is_jz && zero_flag);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_FETCH_OP;
            pc    <= 8'h00;
            acc   <= 8'h00;
            ir    <= 8'h00;
            ar    <= 8'h00;
        end else begin
            case (state)
                ST_FETCH_OP: begin
                    if (mem_ack_in) begin
                        ir <= mem_rdata_in;
                        pc <= pc + 8'd1;
                        if (dec.is_halt) begin
                            state <= ST_HALT;
                        end else if (dec.two_byte) begin
                            state <= ST_FETCH_ARG;
                        end else begin
                            state <= ST_FETCH_OP;
                        end
                    end
                end
                ST_FETCH_ARG: begin
                    if (mem_ack_in) begin
                        ar <= mem_rdata_in;
                        pc <= take_jump ? mem_rdata_in : pc + 8'd1;
                        if (dec.is_alu || dec.is_load) begin
                            state <= ST_EXEC_RD;
                        end else if (dec.is_store) begin
                            state <= ST_EXEC_WR;
                        end else begin
                            state <= ST_FETCH_OP;
                        end
                    end
                end
                ST_EXEC_RD: begin
                    if (mem_ack_in) begin
                        acc   <= acc_nxt;
                        state <= ST_FETCH_OP;
                    end
                end
                ST_EXEC_WR: begin
                    if (mem_ack_in) begin
                        state <= ST_FETCH_OP;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH_OP;
                end
            endcase
        end
    end

`ifdef UL8_ZERO_FLAG_EN
    logic zero_q;
    logic acc_wr;

    assign acc_wr = (state == ST_EXEC_RD) && mem_ack_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            zero_q <= 1'b0;
        end else if (acc_wr) begin
            zero_q <= (acc_nxt == 8'h00);
        end
    end

    assign zero_flag = zero_q;
`else
    assign zero_flag = 1'b0;
`endif

    // Requests are gated by reset so an in-flight access is abandoned without being acked.
    assign mem_rd_out    = !rst_in && ((state == ST_FETCH_OP) || (state == ST_FETCH_ARG)
                                       || (state == ST_EXEC_RD));
    assign mem_wr_out    = !rst_in && (state == ST_EXEC_WR);
    assign mem_addr_out  = ((state == ST_EXEC_RD) || (state == ST_EXEC_WR)) ? ar : pc;
    assign mem_wdata_out = acc;

    assign alu_x_out  = acc;
    assign alu_y_out  = mem_rdata_in;
    assign alu_op_out = ir[1:0];

    assign acc_out    = acc;
    assign pc_out     = pc;
    assign zero_out   = zero_flag;
    assign halted_out = (state == ST_HALT);

endmodule

// File: tb/tb_ul8_sequencer.sv
// Bench for ul8_sequencer: memory responder with random wait states, ISA-level reference model, scoreboard monitor.
module tb_ul8_sequencer;
    import ul8_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] mem_addr_out;
    logic       mem_rd_out;
    logic       mem_wr_out;
    logic [7:0] mem_wdata_out;
    logic [7:0] mem_rdata_in = 8'h00;
    logic       mem_ack_in = 1'b0;
    logic [7:0] alu_x_out;
    logic [7:0] alu_y_out;
    logic [1:0] alu_op_out;
    logic [7:0] alu_z_in;
    logic [7:0] acc_out;
    logic [7:0] pc_out;
    logic       zero_out;
    logic       halted_out;

    ul8_sequencer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mem_addr_out  (mem_addr_out),
        .mem_rd_out    (mem_rd_out),
        .mem_wr_out    (mem_wr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdata_in  (mem_rdata_in),
        .mem_ack_in    (mem_ack_in),
        .alu_x_out     (alu_x_out),
        .alu_y_out     (alu_y_out),
        .alu_op_out    (alu_op_out),
        .alu_z_in      (alu_z_in),
        .acc_out       (acc_out),
        .pc_out        (pc_out),
        .zero_out      (zero_out),
        .halted_out    (halted_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
        case (op)
            ALU_ADD:  return x + y;
            ALU_NAND: return ~(x & y);
            ALU_NOT:  return ~x;
            default:  return 8'h00;
        endcase
    endfunction

    assign alu_z_in = alu_f(alu_x_out, alu_y_out, alu_op_out);

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] mem [256];
    logic [7:0] img [256];
    int         wmin = 0;
    int         wmax = 0;
    int         total_waits = 0;
    int         wr_cycles = 0;
    int         last_cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_acc;
    logic [7:0] exp_pc;
    bit         exp_zero;
    int         exp_ntx;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Memory responder: decides ack at the falling edge so it is stable for the next rising edge.
    initial begin
        int left;
        left = -1;
        forever begin
            @(negedge clk_in);
            mem_ack_in   = 1'b0;
            mem_rdata_in = 8'($urandom);
            if (!rst_in && (mem_rd_out || mem_wr_out)) begin
                if (left < 0) left = int'($urandom_range(wmax, wmin));
                if (left == 0) begin
                    mem_ack_in = 1'b1;
                    if (mem_rd_out) mem_rdata_in = mem[mem_addr_out];
                    else            mem[mem_addr_out] = mem_wdata_out;
                    left = -1;
                end else begin
                    left--;
                    total_waits++;
                end
            end else begin
                left = -1;
            end
        end
    end

    // Monitor: checks request stability and compares each completed access with the scoreboard.
    initial begin
        bit         pend;
        logic [1:0] pkind;
        logic [7:0] paddr;
        logic [7:0] pdat;
        txn_t       t;
        pend = 1'b0;
        forever begin
            @(negedge clk_in);
            #1;
            if (rst_in) begin
                pend = 1'b0;
                continue;
            end
            if (mem_wr_out) wr_cycles++;
            if (mem_rd_out || mem_wr_out) chk8("rd_wr_exclusive", 8'(mem_rd_out & mem_wr_out), 8'h00);
            if (pend) begin
                chk8("req_stable_kind", 8'({mem_wr_out, mem_rd_out}), 8'(pkind));
                chk8("req_stable_addr", mem_addr_out, paddr);
                if (pkind == 2'b10) chk8("req_stable_wdata", mem_wdata_out, pdat);
            end
            if (mem_rd_out || mem_wr_out) begin
                if (mem_ack_in) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_txn: got access at %02h expected none", mem_addr_out);
                    end else begin
                        t = exp_q.pop_front();
                        chk8("txn_kind", 8'(mem_wr_out), 8'(t.wr));
                        chk8("txn_addr", mem_addr_out, t.addr);
                        if (t.wr) chk8("txn_wdata", mem_wdata_out, t.wdata);
                    end
                    pend = 1'b0;
                end else begin
                    pend  = 1'b1;
                    pkind = {mem_wr_out, mem_rd_out};
                    paddr = mem_addr_out;
                    pdat  = mem_wdata_out;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Instruction-level interpreter of the UL8 ISA over a private copy of the image.
    task automatic model_run(output bit ok);
        logic [7:0] rm [256];
        logic [7:0] pc;
        logic [7:0] acc;
        logic [7:0] op;
        logic [7:0] arg;
        bit         z;
        int         n;
        for (int i = 0; i < 256; i++) rm[i] = img[i];
        pc = 8'h00; acc = 8'h00; z = 1'b0; n = 0; ok = 1'b0;
        exp_q.delete();
        for (int step = 0; step < 400; step++) begin
            op = rm[pc];
            exp_q.push_back('{wr: 1'b0, addr: pc, wdata: 8'h00});
            n++;
            pc = pc + 8'd1;
            if (op[7:4] == 4'hF) begin
                ok = 1'b1;
                break;
            end
            if (op[7:4] > 4'h4) continue;
            arg = rm[pc];
            exp_q.push_back('{wr: 1'b0, addr: pc, wdata: 8'h00});
            n++;
            pc = pc + 8'd1;
            case (op[7:4])
                4'h0: begin
                    exp_q.push_back('{wr: 1'b0, addr: arg, wdata: 8'h00});
                    n++;
                    acc = alu_f(acc, rm[arg], op[1:0]);
                    z   = (acc == 8'h00);
                end
                4'h1: begin
                    exp_q.push_back('{wr: 1'b0, addr: arg, wdata: 8'h00});
                    n++;
                    acc = rm[arg];
                    z   = (acc == 8'h00);
                end
                4'h2: begin
                    exp_q.push_back('{wr: 1'b1, addr: arg, wdata: acc});
                    n++;
                    rm[arg] = acc;
                end
                4'h3: pc = arg;
                default: begin
`ifdef UL8_ZERO_FLAG_EN
                    if (z) pc = arg;
`endif
                end
            endcase
        end
        exp_acc = acc;
        exp_pc  = pc;
`ifdef UL8_ZERO_FLAG_EN
        exp_zero = z;
`else
        exp_zero = 1'b0;
`endif
        exp_ntx = n;
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk8({nm, "/rst_pc"}, pc_out, 8'h00);
        chk8({nm, "/rst_acc"}, acc_out, 8'h00);
        chk8({nm, "/rst_zero"}, 8'(zero_out), 8'h00);
        chk8({nm, "/rst_halted"}, 8'(halted_out), 8'h00);
        chk8({nm, "/rst_req"}, 8'({mem_wr_out, mem_rd_out}), 8'h00);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        total_waits = 0;
        wr_cycles   = 0;
    endtask

    task automatic run_prog(input string nm, input int lo, input int hi);
        bit ok;
        int cyc;
        int budget;
        model_run(ok);
        for (int i = 0; i < 256; i++) mem[i] = img[i];
        wmin = lo;
        wmax = hi;
        do_reset(nm);
        cyc    = 0;
        budget = exp_ntx * (hi + 1) + 20;
        @(negedge clk_in);
        #1;
        chk8({nm, "/first_rd"}, 8'({mem_wr_out, mem_rd_out}), 8'h01);
        chk8({nm, "/first_addr"}, mem_addr_out, 8'h00);
        while (!halted_out && cyc < budget) begin
            cyc++;
            @(negedge clk_in);
            #1;
        end
        last_cyc = cyc;
        chk8({nm, "/halted"}, 8'(halted_out), 8'h01);
        chki({nm, "/cycles"}, cyc, exp_ntx + total_waits);
        chk8({nm, "/acc"}, acc_out, exp_acc);
        chk8({nm, "/pc"}, pc_out, exp_pc);
        chk8({nm, "/zero"}, 8'(zero_out), 8'(exp_zero));
        chki({nm, "/txns_left"}, exp_q.size(), 0);
        @(negedge clk_in);
        #1;
        chk8({nm, "/idle_after_halt"}, 8'({mem_wr_out, mem_rd_out, halted_out}), 8'h01);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'hF0;
    endtask

    task automatic gen_random();
        int         a;
        int         k;
        logic [7:0] tgt;
        for (int i = 0; i < 256; i++)
            img[i] = (i >= 128) ? (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)) : 8'hF0;
        a = 0;
        while (a < 'h5E) begin
            k = int'($urandom_range(0, 9));
            if (k == 7) begin
                img[a] = {4'($urandom_range(5, 14)), 4'($urandom)};
                a++;
            end else begin
                tgt = 8'(a + 2 + 2 * int'($urandom_range(0, 6)));
                if (tgt > 8'h60) tgt = 8'h60;
                case (k)
                    3:       img[a] = 8'h10;
                    4:       img[a] = 8'h20;
                    5:       img[a] = 8'h30;
                    6:       img[a] = 8'h40;
                    default: img[a] = {6'h00, 2'($urandom)};
                endcase
                img[a + 1] = (k == 5 || k == 6) ? tgt : 8'($urandom_range(128, 255));
                a += 2;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int seen;
        repeat (2) @(posedge clk_in);

        // LOAD then ADD, zero wait: 3+3+1 cycles.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h00; img[3] = 8'h21; img[4] = 8'hF0;
        img[8'h20] = 8'h05; img[8'h21] = 8'h07;
        run_prog("load_add", 0, 0);
        chk8("load_add/acc_const", acc_out, 8'h0C);
        chk8("load_add/pc_const", pc_out, 8'h05);
        chki("load_add/cycles_const", last_cyc, 7);

        // NAND, NOT and ZERO with the intermediates stored for inspection.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h01; img[3] = 8'h21;
        img[4] = 8'h20; img[5] = 8'h80; img[6] = 8'h02; img[7] = 8'h21;
        img[8] = 8'h20; img[9] = 8'h81; img[10] = 8'h03; img[11] = 8'h21; img[12] = 8'hF0;
        img[8'h20] = 8'hF0; img[8'h21] = 8'h3C;
        run_prog("alu_ops", 0, 1);
        chk8("alu_ops/nand_result", mem[8'h80], 8'hCF);
        chk8("alu_ops/not_result", mem[8'h81], 8'h30);
        chk8("alu_ops/zero_acc", acc_out, 8'h00);
`ifdef UL8_ZERO_FLAG_EN
        chk8("alu_ops/zero_flag", 8'(zero_out), 8'h01);
`else
        chk8("alu_ops/zero_flag", 8'(zero_out), 8'h00);
`endif

        // STORE with three wait cycles on every access.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h20; img[3] = 8'h80; img[4] = 8'hF0;
        img[8'h20] = 8'hA5; img[8'h80] = 8'h00;
        run_prog("store_wait", 3, 3);
        chki("store_wait/wr_cycles", wr_cycles, 4);
        chk8("store_wait/mem80", mem[8'h80], 8'hA5);

        // JMP to 0xFE, arg fetch at 0xFF wraps PC; JZ not taken advances by 2.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h40; img[3] = 8'h10;
        img[4] = 8'h30; img[5] = 8'hFE; img[8'hFE] = 8'h20; img[8'hFF] = 8'h02;
        img[8'h20] = 8'hF0;
        run_prog("jmp_wrap", 0, 2);
        chk8("jmp_wrap/pc_const", pc_out, 8'h03);
        chk8("jmp_wrap/selfmod", mem[8'h02], 8'hF0);

        // JZ with zero set: taken only when the flag exists.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h21; img[2] = 8'h40; img[3] = 8'h08;
        img[4] = 8'hF0; img[8] = 8'hF0; img[8'h21] = 8'h00;
        run_prog("jz_taken", 0, 1);
`ifdef UL8_ZERO_FLAG_EN
        chk8("jz_taken/pc_const", pc_out, 8'h09);
`else
        chk8("jz_taken/pc_const", pc_out, 8'h05);
`endif

        // Unknown opcode is a one-byte, one-cycle NOP.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h20; img[2] = 8'h7A; img[3] = 8'hF0;
        img[8'h20] = 8'h55;
        run_prog("nop", 0, 0);
        chk8("nop/acc_const", acc_out, 8'h55);
        chk8("nop/pc_const", pc_out, 8'h04);
        chki("nop/cycles_const", last_cyc, 5);

        // Reset during the EXEC_RD wait of the second LOAD.
        clear_img();
        img[0] = 8'h10; img[1] = 8'h21; img[2] = 8'h10; img[3] = 8'h20; img[4] = 8'hF0;
        img[8'h20] = 8'h77; img[8'h21] = 8'h33;
        for (int i = 0; i < 256; i++) mem[i] = img[i];
        wmin = 4;
        wmax = 4;
        exp_q.delete();
        exp_q.push_back('{wr: 1'b0, addr: 8'h00, wdata: 8'h00});
        exp_q.push_back('{wr: 1'b0, addr: 8'h01, wdata: 8'h00});
        exp_q.push_back('{wr: 1'b0, addr: 8'h21, wdata: 8'h00});
        exp_q.push_back('{wr: 1'b0, addr: 8'h02, wdata: 8'h00});
        exp_q.push_back('{wr: 1'b0, addr: 8'h03, wdata: 8'h00});
        do_reset("abort");
        seen = 0;
        for (int c = 0; c < 80 && seen == 0; c++) begin
            @(negedge clk_in);
            #1;
            if (mem_rd_out && mem_addr_out == 8'h20) seen = 1;
        end
        chki("abort/exec_rd_reached", seen, 1);
        chk8("abort/acc_before", acc_out, 8'h33);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        exp_q.delete();
        @(negedge clk_in);
        #1;
        chk8("abort/req_dropped", 8'({mem_wr_out, mem_rd_out}), 8'h00);
        @(negedge clk_in);
        #1;
        chk8("abort/acc", acc_out, 8'h00);
        chk8("abort/pc", pc_out, 8'h00);
        chk8("abort/req_in_reset", 8'({mem_wr_out, mem_rd_out}), 8'h00);
        run_prog("abort_recover", 0, 1);
        chk8("abort_recover/acc_const", acc_out, 8'h77);

        // Random programs with random wait states.
        for (int r = 0; r < 10; r++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                gen_random();
                model_run(ok);
            end
            if (ok) run_prog($sformatf("rand%0d", r), 0, r % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ul8_sequencer.md
# ul8_sequencer

Fetch/execute controller for the UL8 8-bit CPU; it sits directly upstream of the ALU. It fetches two-byte instructions from a shared 8-bit memory over a request/acknowledge interface and drives the ALU's x, y and opcode inputs. It writes the ALU result back into the accumulator and handles loads, stores, jumps and halt.

## Interface
- No parameters; all widths are fixed at 8-bit data and 8-bit address.
- clk_in  input  1  sole clock; all state updates on the rising edge
- rst_in  input  1  synchronous, active-high reset
- mem_addr_out  output  8  memory address
- mem_rd_out  output  1  read request
- mem_wr_out  output  1  write request
- mem_wdata_out  output  8  write data (always ACC)
- mem_rdata_in  input  8  read data; valid only while mem_ack_in=1
- mem_ack_in  input  1  completes the pending request in this cycle
- alu_x_out  output  8  ALU x operand (always ACC)
- alu_y_out  output  8  ALU y operand (combinational copy of mem_rdata_in)
- alu_op_out  output  2  ALU opcode (instr[1:0])
- alu_z_in  input  8  ALU result
- acc_out  output  8  accumulator
- pc_out  output  8  program counter
- zero_out  output  1  zero flag
- halted_out  output  1  high in HALT state

## Operation
- Opcode byte encoding, by op[7:4]:
  - 0x0 ALU: ACC <= ACC op MEM[arg], using ALU op = op[1:0]. Op 2 (NOT) and op 3 (zero) still perform the operand read.
  - 0x1 LOAD: ACC <= MEM[arg].
  - 0x2 STORE: MEM[arg] <= ACC.
  - 0x3 JMP: PC <= arg.
  - 0x4 JZ: PC <= arg if zero flag is set.
  - 0xF HALT: one byte.
  - Any other value is a one-byte NOP.
- States:
  - FETCH_OP: read MEM[PC]; on ack, latch IR and PC+1. Go to HALT, back to FETCH_OP (NOP), or to FETCH_ARG.
  - FETCH_ARG: read MEM[PC]; on ack, latch AR and PC+1. JMP/JZ resolve here (a taken jump overrides the PC increment) and return to FETCH_OP. ALU/LOAD go to EXEC_RD; STORE goes to EXEC_WR.
  - EXEC_RD: read MEM[AR]; on ack, ACC <= alu_z_in (ALU) or mem_rdata_in (LOAD); go to FETCH_OP.
  - EXEC_WR: write ACC to MEM[AR]; on ack, go to FETCH_OP.
  - HALT: no requests; leaves only via reset.
- Requests stay asserted, with a stable address, until ack is sampled high. Wait states are unlimited.
- mem_rd_out and mem_wr_out are never both high.
- PC wraps 0xFF→0x00, including during an argument fetch at 0xFF.
- The zero flag is updated only on an ACC write: zero = (new ACC == 0).

## Timing
- While rst_in is high, and in the first cycle after it:
  - PC=0, ACC=0, zero=0, IR=AR=0, state=FETCH_OP.
  - mem_rd_out and mem_wr_out are 0 during the reset cycle.
- From the first cycle after reset deasserts, mem_rd_out=1 with mem_addr_out=0x00.
- With zero-wait ack, instruction latencies are:
  - ALU/LOAD/STORE: 3 cycles.
  - JMP/JZ: 2 cycles.
  - NOP: 1 cycle.
  - HALT: 1 cycle, then halted_out=1 from the next cycle.
- Each wait cycle (ack low) adds exactly one cycle.
- The ALU is combinational: alu_z_in is sampled in the same cycle that mem_ack_in completes EXEC_RD.
- Reset asserted mid-transaction drops the request the next cycle. ACC, PC and memory are not written by that transaction.

## Configuration
- UL8_ZERO_FLAG_EN defined:
  - zero flag register present.
  - JZ decoded as a conditional jump.
- UL8_ZERO_FLAG_EN undefined:
  - zero_out tied to 0 and no flag register.
  - opcode 0x4 is a two-byte NOP: the argument is fetched and discarded, and PC advances by 2.

## Structure
- Shared package ul8_pkg holds:
  - opcode class constants (ALU, LOAD, STORE, JMP, JZ, HALT);
  - ALU op encodings (ADD=0, NAND=1, NOT=2, ZERO=3);
  - the sequencer state enumeration.
- Sub-module ul8_decode: combinational IR → {is_alu, is_load, is_store, is_jmp, is_jz, is_halt, two_byte}. It is the only place where UL8_ZERO_FLAG_EN affects decode.

## Test plan
- **LOAD/ADD.** Memory {0x10,0x20, 0x00,0x21, 0xF0}, with MEM[0x20]=0x05 and MEM[0x21]=0x07, zero-wait. Required: ACC=0x0C, halted_out=1 after 3+3+1 cycles, PC=0x05.
- **NAND/NOT/zero.** ACC=0xF0, run NAND with 0x3C → ACC=0xCF; then NOT → 0x30; then op 3 → ACC=0x00, zero_out=1.
- **STORE with waits.** STORE to 0x80 with ack delayed 3 cycles. Required: mem_wr_out high for exactly 4 cycles, address 0x80 and data = ACC held stable, a single write.
- **Jumps.** JMP 0xFE, then fetch continues at 0xFE/0xFF; an argument at 0xFF wraps PC to 0x00. JZ taken when zero=1; not taken when zero=0, where PC advances by 2. With UL8_ZERO_FLAG_EN undefined, JZ always falls through.
- **Reset mid-operation.** Assert rst_in during the EXEC_RD wait. Required: next cycle mem_rd_out=0, ACC=0, PC=0. After release, fetch from 0x00.
- **Unknown opcode.** Opcode 0x7A → one-byte NOP: PC+1, no ACC change, 1 cycle.
